// File: rtl/from_boot_sequencer_pkg.sv
// Shared constants for the FROM boot sequencer.
// Also consumed by the FROM-image generation script.
package from_boot_sequencer_pkg;

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [6:0] FBS_BASE_ADDR = 7'd0;
    localparam logic [6:0] FBS_COUNT     = 7'd16;
    localparam logic [7:0] FBS_TIMEOUT   = 8'd32;

endpackage

// File: rtl/from_boot_sequencer.sv
// Boot loader in front of the FROM slave: streams the config image out,
// verifies its checksum, then hands the slave over to the host.
module from_boot_sequencer
    import from_boot_sequencer_pkg::*;
#(
    parameter logic [6:0] BASE_ADDR = FBS_BASE_ADDR,
    parameter logic [6:0] COUNT     = FBS_COUNT,
    parameter logic [7:0] TIMEOUT   = FBS_TIMEOUT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        cfg_we_o,
    output logic [6:0]  cfg_adr_o,
    output logic [7:0]  cfg_dat_o,
    input  logic        reload_i,
    output logic        boot_done_o,
    output logic        boot_err_o
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [6:0] idx;
    logic [7:0] sum;
    logic [7:0] timer;
    logic [7:0] timer_inc;
    logic [7:0] rd_byte;
    logic [7:0] sum_nxt;
    logic       m_cyc;
    logic       m_stb;
    logic [6:0] m_adr;
    logic       reload_pend;
    logic       reload_go;
    logic       host_busy;
    logic       last_byte;
    logic       timed_out;

    assign rd_byte   = wbm_dat_i[7:0];
    assign sum_nxt   = sum + rd_byte;
    assign last_byte = (idx == COUNT);

    // The timer counts the current wait cycle before comparing, so the
    // strobe stays up for exactly TIMEOUT cycles on a dead slave.
    assign timer_inc = (timer == TIMEOUT) ? timer : timer + 8'd1;
    assign timed_out = (timer_inc == TIMEOUT);

    // A pending reload never cuts an outstanding host access short.
    assign host_busy = wb_cyc_i & wb_stb_i;
    assign reload_go = (reload_pend | reload_i) & (~host_busy | wbm_ack_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wbm_ack_i) begin
                    state_nxt = last_byte ? S_RUN : S_GAP;
                end else if (timed_out) begin
                    state_nxt = S_RUN;
                end
            end
            S_GAP: state_nxt = S_ISSUE;
            S_RUN: begin
                if (reload_go) begin
                    state_nxt = S_ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            idx         <= '0;
            sum         <= '0;
            timer       <= '0;
            m_cyc       <= 1'b0;
            m_stb       <= 1'b0;
            m_adr       <= '0;
            cfg_we_o    <= 1'b0;
            cfg_adr_o   <= '0;
            cfg_dat_o   <= '0;
            boot_done_o <= 1'b0;
            boot_err_o  <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            cfg_we_o <= 1'b0;
            unique case (state)
                S_ISSUE: begin
                    m_cyc <= 1'b1;
                    m_stb <= 1'b1;
                    m_adr <= BASE_ADDR + idx;
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer_inc;
                    if (wbm_ack_i) begin
                        m_cyc <= 1'b0;
                        m_stb <= 1'b0;
                        if (last_byte) begin
                            boot_err_o  <= (sum_nxt != 8'd0);
                            boot_done_o <= 1'b1;
                        end else begin
                            cfg_we_o  <= 1'b1;
                            cfg_adr_o <= idx;
                            cfg_dat_o <= rd_byte;
                            sum       <= sum_nxt;
                            idx       <= idx + 7'd1;
                        end
                    end else if (timed_out) begin
                        m_cyc       <= 1'b0;
                        m_stb       <= 1'b0;
                        boot_err_o  <= 1'b1;
                        boot_done_o <= 1'b1;
                    end
                end
                S_GAP: begin
                end
                S_RUN: begin
                    if (reload_go) begin
                        boot_done_o <= 1'b0;
                        boot_err_o  <= 1'b0;
                        idx         <= '0;
                        sum         <= '0;
                        reload_pend <= 1'b0;
                    end else if (reload_i) begin
                        reload_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wbm_cyc_o = m_cyc;
        wbm_stb_o = m_stb;
        wbm_we_o  = 1'b0;
        wbm_adr_o = {9'b0, m_adr};
        wbm_dat_o = '0;
        wb_ack_o  = 1'b0;
        wb_dat_o  = '0;
        if (state == S_RUN) begin
            wbm_cyc_o = wb_cyc_i;
            wbm_stb_o = wb_stb_i;
            wbm_we_o  = wb_we_i;
            wbm_adr_o = wb_adr_i;
            wbm_dat_o = wb_dat_i;
            wb_ack_o  = wbm_ack_i;
            wb_dat_o  = wbm_dat_i;
        end
    end

endmodule

// File: doc/from_boot_sequencer.md
Name: from_boot_sequencer

Overview:
Sits between the host Wishbone master and the FROM Wishbone slave (`from_controller`), and owns access to that slave.
- After reset or on `reload_i`, it holds off the host and reads a configuration image from FROM.
- Each data byte is streamed out on a config-write port.
- A trailing checksum byte is verified, then the block reports `boot_done_o` / `boot_err_o`.
- After boot, host cycles pass through to the FROM slave unchanged.

Parameters:
- BASE_ADDR, 7'd0, FROM address of the first image byte.
- COUNT, 7'd16, number of data bytes (1..126). The checksum byte sits at BASE_ADDR+COUNT; BASE_ADDR+COUNT must be ≤ 127.
- TIMEOUT, 8'd32, cycles allowed per FROM read before it is declared failed.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_cyc_i  in  1  host cycle
- wb_stb_i  in  1  host strobe
- wb_we_i  in  1  host write enable
- wb_adr_i  in  16  host address
- wb_dat_i  in  16  host write data
- wb_dat_o  out  16  host read data
- wb_ack_o  out  1  host acknowledge
- wbm_cyc_o  out  1  cycle to FROM slave
- wbm_stb_o  out  1  strobe to FROM slave
- wbm_we_o  out  1  write enable to FROM slave
- wbm_adr_o  out  16  address to FROM slave
- wbm_dat_o  out  16  write data to FROM slave
- wbm_dat_i  in  16  read data from FROM slave (byte in [7:0])
- wbm_ack_i  in  1  acknowledge from FROM slave
- cfg_we_o  out  1  one-cycle config write strobe
- cfg_adr_o  out  7  config byte index, 0..COUNT-1
- cfg_dat_o  out  8  config byte
- reload_i  in  1  single-cycle pulse requesting a re-boot
- boot_done_o  out  1  image load finished (pass or fail)
- boot_err_o  out  1  checksum mismatch or read timeout

Behaviour:
- Clock and reset: one clock, `wb_clk_i`. Reset `wb_rst_i` is synchronous and active-high.
- Reset values: `boot_done_o`=0, `boot_err_o`=0, `cfg_we_o`=0, `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0, `wb_ack_o`=0, idx=0, sum=0, state=S_ISSUE.
- States:
  - S_ISSUE: drive registered `wbm_cyc_o`=`wbm_stb_o`=1, `wbm_we_o`=0, `wbm_adr_o`={9'b0, BASE_ADDR+idx}. Clear the timer and go to S_WAIT.
  - S_WAIT: the timer increments every cycle.
    - On `wbm_ack_i` with idx<COUNT: set `cfg_we_o`=1 for exactly one cycle, with `cfg_adr_o`=idx and `cfg_dat_o`=`wbm_dat_i`[7:0]. Update sum=(sum+byte) mod 256, idx++, drop cyc/stb next cycle, go to S_GAP.
    - On `wbm_ack_i` with idx==COUNT: `boot_err_o`=((sum+byte) mod 256 != 0), `boot_done_o`=1, drop cyc/stb, go to S_RUN.
    - If timer==TIMEOUT with no ack: `boot_err_o`=1, `boot_done_o`=1, drop cyc/stb, go to S_RUN.
  - S_GAP: one idle cycle with stb low, so the slave's one-cycle ack is never mistaken for a new request. Then go to S_ISSUE.
  - S_RUN: pass-through, combinational.
    - `wbm_cyc_o`/`stb`/`we`/`adr`/`dat` = `wb_cyc_i`/`stb`/`we`/`adr`/`dat`.
    - `wb_ack_o`=`wbm_ack_i`, `wb_dat_o`=`wbm_dat_i`.
- Host during boot (any state except S_RUN): `wb_ack_o`=0 and `wb_dat_o`=0. The host stalls with its cycle held and is serviced once S_RUN is entered.
- Reload:
  - A `reload_i` pulse in S_RUN is latched as pending.
  - If the host has `wb_cyc_i&wb_stb_i` high, the reload waits until the cycle after that host `wbm_ack_i` (the ack is still passed to the host), or until `wb_cyc_i` drops.
  - When the reload starts: clear `boot_done_o`, `boot_err_o`, idx and sum, then go to S_ISSUE.
  - `reload_i` during boot is ignored.
- Simultaneous events: if ack and timeout coincide, the ack wins.
- Reset mid-operation: reset mid-boot restarts the boot from idx=0 with no further `cfg_we_o`. The FROM slave shares `wb_rst_i`, so no stale ack arrives.
- Latency: one FROM read is the slave latency (4–8 cycles) plus 2 cycles (issue + gap). Total boot time ≈ (COUNT+1)×(slave latency+2).
- Widths: idx is 7 bits and sum is 8 bits, both wrapping mod 2^n. The timer is 8 bits and saturates at TIMEOUT.

Decomposition:
- Shared package/header: state localparams (S_ISSUE, S_WAIT, S_GAP, S_RUN; 2-bit encoding) and default BASE_ADDR/COUNT/TIMEOUT, shared with the FROM-image generation script.
- No sub-module. The mux, FSM and checksum live in one module.

Test Plan:
- Good image: COUNT=4, FROM[0..4]=0x11,0x22,0x33,0x44,0x56 → four `cfg_we_o` pulses (adr 0..3, data 0x11..0x44), then `boot_done_o`=1, `boot_err_o`=0.
- Bad checksum: same image with FROM[4]=0x57 → four cfg writes, then `boot_done_o`=1, `boot_err_o`=1.
- Timeout: `wbm_ack_i` tied 0 → exactly TIMEOUT=32 cycles after the first stb, `boot_done_o`=1, `boot_err_o`=1, zero cfg writes, pass-through active.
- Host during boot: host reads adr 0x0002 at reset release → no `wb_ack_o` until `boot_done_o`, then host receives `wb_dat_o`=0x0033 with one ack pulse.
- Reload during host read: `reload_i` pulsed while a host read is outstanding → host gets its ack and data first, then `boot_done_o` falls and the image is re-read, with four cfg writes repeated.
- Reset mid-boot: assert `wb_rst_i` after the 2nd cfg write → outputs return to reset values, and the boot restarts at cfg_adr 0.
